// File: rtl/axi_mem_pkg.sv
// Shared types for axi_burst_mem: response codes, FSM state enums and the pmem access model.
// pmem_read/pmem_write act on a sparse 64-bit word store; call counts and a write log are kept alongside.
package axi_mem_pkg;

  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;

  typedef enum logic [1:0] {R_IDLE, R_WAIT, R_DATA} rd_state_e;
  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wr_state_e;

  logic [63:0] pmem_words [logic [63:0]];
  int unsigned pmem_rd_calls = 0;
  int unsigned pmem_wr_calls = 0;
  logic [7:0]  pmem_wr_strb_q [$];
  logic [63:0] pmem_wr_addr_q [$];

  function automatic logic [63:0] pmem_read(input logic [63:0] addr);
    logic [63:0] key;
    key = addr & ~64'h7;
    pmem_rd_calls++;
    if (pmem_words.exists(key)) return pmem_words[key];
    return 64'h0;
  endfunction

  // Byte-merge into the addressed word; unwritten words read as zero.
  function automatic void pmem_write(input logic [63:0] addr, input logic [63:0] data,
                                     input logic [7:0] strb);
    logic [63:0] key;
    logic [63:0] word;
    key  = addr & ~64'h7;
    word = pmem_words.exists(key) ? pmem_words[key] : 64'h0;
    for (int b = 0; b < 8; b++) begin
      if (strb[b]) word[8*b +: 8] = data[8*b +: 8];
    end
    pmem_words[key] = word;
    pmem_wr_calls++;
    pmem_wr_strb_q.push_back(strb);
    pmem_wr_addr_q.push_back(addr);
  endfunction

endpackage

// File: rtl/axi_burst_addr.sv
// INCR beat address step and per-lane 64-bit word addresses; purely combinational, zero latency.
// No handshake: follows its address/size inputs every cycle.
module axi_burst_addr #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64
) (
  input  logic [ADDR_W-1:0] addr,
  input  logic [2:0]        size,
  output logic [ADDR_W-1:0] next_addr,
  output logic [DATA_W-1:0] lane_addr
);
  localparam int LANES = DATA_W / 64;
  localparam int BYTES = DATA_W / 8;

  logic [ADDR_W-1:0] step;
  logic [63:0]       base;

  always_comb begin
    step      = ADDR_W'(1) << size;
    next_addr = (addr & ~(step - ADDR_W'(1))) + step;
    base      = 64'(addr) & ~64'(BYTES - 1);
    for (int i = 0; i < LANES; i++) begin
      lane_addr[64*i +: 64] = base + 64'(8 * i);
    end
  end
endmodule

// File: rtl/axi_burst_mem.sv
// AXI4 INCR burst memory slave on pmem_read/pmem_write; independent read and write FSMs.
// First rvalid RD_LAT+1 cycles after AR, then one beat per rready; W one beat per cycle, B held until bready.
module axi_burst_mem
  import axi_mem_pkg::*;
#(
  parameter int DATA_W = 64,
  parameter int ID_W   = 4,
  parameter int ADDR_W = 64,
  parameter int RD_LAT = 1
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [ID_W-1:0]     arid,
  input  logic [ADDR_W-1:0]   araddr,
  input  logic [7:0]          arlen,
  input  logic [2:0]          arsize,
  input  logic                arvalid,
  output logic                arready,
  output logic [ID_W-1:0]     rid,
  output logic [DATA_W-1:0]   rdata,
  output logic [1:0]          rresp,
  output logic                rlast,
  output logic                rvalid,
  input  logic                rready,
  input  logic [ID_W-1:0]     awid,
  input  logic [ADDR_W-1:0]   awaddr,
  input  logic [7:0]          awlen,
  input  logic [2:0]          awsize,
  input  logic                awvalid,
  output logic                awready,
  input  logic [DATA_W-1:0]   wdata,
  input  logic [DATA_W/8-1:0] wstrb,
  input  logic                wlast,
  input  logic                wvalid,
  output logic                wready,
  output logic [ID_W-1:0]     bid,
  output logic [1:0]          bresp,
  output logic                bvalid,
  input  logic                bready
);
  localparam int         LANES    = DATA_W / 64;
  localparam int         BYTES    = DATA_W / 8;
  localparam logic [2:0] MAX_SIZE = 3'($clog2(BYTES));

  rd_state_e         r_state_q, r_state_d;
  logic [ID_W-1:0]   rid_q, rid_d;
  logic [ADDR_W-1:0] raddr_q, raddr_d, r_next;
  logic [7:0]        rlen_q, rlen_d, rcnt_q, rcnt_d;
  logic [2:0]        rsize_q, rsize_d;
  logic [3:0]        rwait_q, rwait_d;
  logic              arready_q, arready_d, rvalid_q, rvalid_d, rlast_q, rlast_d;
  logic [1:0]        rresp_q, rresp_d;
  logic [DATA_W-1:0] rdata_q, r_lane;
  logic              r_fetch, r_err;

  wr_state_e         w_state_q, w_state_d;
  logic [ID_W-1:0]   wid_q, wid_d, bid_q, bid_d;
  logic [ADDR_W-1:0] waddr_q, waddr_d, w_next;
  logic [7:0]        wlen_q, wlen_d, wcnt_q, wcnt_d;
  logic [2:0]        wsize_q, wsize_d;
  logic              awready_q, awready_d, wready_q, wready_d, bvalid_q, bvalid_d;
  logic              wbad_q, wbad_d;
  logic [1:0]        bresp_q, bresp_d;
  logic [DATA_W-1:0] w_lane;
  logic              w_fire, w_err;

  // raddr_q always holds the address of the next beat to fetch, so one address unit suffices.
  axi_burst_addr #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_raddr (
    .addr(raddr_q), .size(rsize_q), .next_addr(r_next), .lane_addr(r_lane)
  );
  axi_burst_addr #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_waddr (
    .addr(waddr_q), .size(wsize_q), .next_addr(w_next), .lane_addr(w_lane)
  );

  assign r_err = (rsize_q > MAX_SIZE);
  assign w_err = (wsize_q > MAX_SIZE);

  always_comb begin
    r_state_d = r_state_q;
    rid_d     = rid_q;
    raddr_d   = raddr_q;
    rlen_d    = rlen_q;
    rsize_d   = rsize_q;
    rcnt_d    = rcnt_q;
    rwait_d   = rwait_q;
    rvalid_d  = rvalid_q;
    rlast_d   = rlast_q;
    rresp_d   = rresp_q;
    r_fetch   = 1'b0;
    case (r_state_q)
      R_IDLE: begin
        if (arvalid && arready_q) begin
          r_state_d = R_WAIT;
          rid_d     = arid;
          raddr_d   = araddr;
          rlen_d    = arlen;
          rsize_d   = arsize;
          rwait_d   = 4'(RD_LAT);
        end
      end
      R_WAIT: begin
        if (rwait_q == 4'd0) begin
          r_state_d = R_DATA;
          r_fetch   = 1'b1;
          raddr_d   = r_next;
          rcnt_d    = 8'd0;
          rvalid_d  = 1'b1;
          rlast_d   = (rlen_q == 8'd0);
          rresp_d   = r_err ? SLVERR : OKAY;
        end else begin
          rwait_d = rwait_q - 4'd1;
        end
      end
      R_DATA: begin
        if (rready) begin
          if (rlast_q) begin
            r_state_d = R_IDLE;
            rvalid_d  = 1'b0;
            rlast_d   = 1'b0;
          end else begin
            r_fetch = 1'b1;
            raddr_d = r_next;
            rcnt_d  = rcnt_q + 8'd1;
            rlast_d = ((rcnt_q + 8'd1) == rlen_q);
          end
        end
      end
      default: r_state_d = R_IDLE;
    endcase
    arready_d = (r_state_d == R_IDLE);
  end

  always_comb begin
    w_state_d = w_state_q;
    wid_d     = wid_q;
    waddr_d   = waddr_q;
    wlen_d    = wlen_q;
    wsize_d   = wsize_q;
    wcnt_d    = wcnt_q;
    wbad_d    = wbad_q;
    bid_d     = bid_q;
    bresp_d   = bresp_q;
    bvalid_d  = bvalid_q;
    w_fire    = 1'b0;
    case (w_state_q)
      W_IDLE: begin
        if (awvalid && awready_q) begin
          w_state_d = W_DATA;
          wid_d     = awid;
          waddr_d   = awaddr;
          wlen_d    = awlen;
          wsize_d   = awsize;
          wcnt_d    = 8'd0;
          wbad_d    = 1'b0;
        end
      end
      W_DATA: begin
        if (wvalid && wready_q) begin
          w_fire  = 1'b1;
          waddr_d = w_next;
          wcnt_d  = wcnt_q + 8'd1;
          // The beat count closes the burst; wlast only grades it.
          if (wlast != (wcnt_q == wlen_q)) wbad_d = 1'b1;
          if (wcnt_q == wlen_q) begin
            w_state_d = W_RESP;
            bvalid_d  = 1'b1;
            bid_d     = wid_q;
            bresp_d   = (w_err || wbad_d) ? SLVERR : OKAY;
          end
        end
      end
      W_RESP: begin
        if (bready) begin
          w_state_d = W_IDLE;
          bvalid_d  = 1'b0;
        end
      end
      default: w_state_d = W_IDLE;
    endcase
    awready_d = (w_state_d == W_IDLE);
    wready_d  = (w_state_d == W_DATA);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state_q <= R_IDLE;
      rid_q     <= '0;
      raddr_q   <= '0;
      rlen_q    <= '0;
      rsize_q   <= '0;
      rcnt_q    <= '0;
      rwait_q   <= '0;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rlast_q   <= 1'b0;
      rresp_q   <= OKAY;
      rdata_q   <= '0;
      w_state_q <= W_IDLE;
      wid_q     <= '0;
      waddr_q   <= '0;
      wlen_q    <= '0;
      wsize_q   <= '0;
      wcnt_q    <= '0;
      wbad_q    <= 1'b0;
      bid_q     <= '0;
      bresp_q   <= OKAY;
      bvalid_q  <= 1'b0;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
    end else begin
      r_state_q <= r_state_d;
      rid_q     <= rid_d;
      raddr_q   <= raddr_d;
      rlen_q    <= rlen_d;
      rsize_q   <= rsize_d;
      rcnt_q    <= rcnt_d;
      rwait_q   <= rwait_d;
      arready_q <= arready_d;
      rvalid_q  <= rvalid_d;
      rlast_q   <= rlast_d;
      rresp_q   <= rresp_d;
      w_state_q <= w_state_d;
      wid_q     <= wid_d;
      waddr_q   <= waddr_d;
      wlen_q    <= wlen_d;
      wsize_q   <= wsize_d;
      wcnt_q    <= wcnt_d;
      wbad_q    <= wbad_d;
      bid_q     <= bid_d;
      bresp_q   <= bresp_d;
      bvalid_q  <= bvalid_d;
      awready_q <= awready_d;
      wready_q  <= wready_d;
      // Writes are issued ahead of reads so a same-edge read observes the new data.
      if (w_fire && !w_err) begin
        for (int i = 0; i < LANES; i++) begin
          if (wstrb[8*i +: 8] != 8'h00)
            pmem_write(w_lane[64*i +: 64], wdata[64*i +: 64], wstrb[8*i +: 8]);
        end
      end
      if (r_fetch) begin
        for (int i = 0; i < LANES; i++) begin
          if (r_err) rdata_q[64*i +: 64] <= 64'h0;
          else       rdata_q[64*i +: 64] <= pmem_read(r_lane[64*i +: 64]);
        end
      end
    end
  end

  assign arready = arready_q;
  assign rid     = rid_q;
  assign rdata   = rdata_q;
  assign rresp   = rresp_q;
  assign rlast   = rlast_q;
  assign rvalid  = rvalid_q;
  assign awready = awready_q;
  assign wready  = wready_q;
  assign bid     = bid_q;
  assign bresp   = bresp_q;
  assign bvalid  = bvalid_q;
endmodule
